// File: rtl/rtc_calendar_core_if.sv
// Control and display bundle between the DE2 clock front panel and the RTC calendar core.
interface rtc_calendar_core_if;
    logic       run_en;
    logic       edit_en;
    logic [2:0] edit_field;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] hour12;
    logic       pm;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic       tick_1hz;
    logic       blink;

    modport master (
        output run_en, edit_en, edit_field, inc_pulse, dec_pulse,
        input  sec, min, hour, hour12, pm, day, month, year, tick_1hz, blink
    );

    modport slave (
        input  run_en, edit_en, edit_field, inc_pulse, dec_pulse,
        output sec, min, hour, hour12, pm, day, month, year, tick_1hz, blink
    );
endinterface

// File: rtl/rtc_calendar_core.sv
// Timekeeping core: 1 Hz prescaler, sec/min/hour with a leap-aware day/month/year calendar,
// per-field edit stepping with time frozen, and a free-running display blink clock.
module rtc_calendar_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    rtc_calendar_core_if.slave bus
);
    localparam int PRESC_W  = $clog2(CLK_HZ + 1);
    localparam int BLINK_TC = CLK_HZ / (2 * BLINK_HZ) - 1;
    localparam int BLINK_W  = $clog2(BLINK_TC + 2);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TC);

    localparam logic [2:0] FIELD_SEC   = 3'd0;
    localparam logic [2:0] FIELD_MIN   = 3'd1;
    localparam logic [2:0] FIELD_HOUR  = 3'd2;
    localparam logic [2:0] FIELD_DAY   = 3'd3;
    localparam logic [2:0] FIELD_MONTH = 3'd4;
    localparam logic [2:0] FIELD_YEAR  = 3'd5;

    logic [5:0]         sec_q, sec_n;
    logic [5:0]         min_q, min_n;
    logic [4:0]         hour_q, hour_n;
    logic [4:0]         day_q, day_n;
    logic [3:0]         month_q, month_n;
    logic [6:0]         year_q, year_n;
    logic [PRESC_W-1:0] presc_q, presc_n;
    logic               tick_q, tick_n;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_n;
    logic               blink_q, blink_n;
    logic [4:0]         cur_dim;
    logic [4:0]         new_dim;
    logic [3:0]         hour12_c;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = ((y % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Edit stepping wraps inside the field's own range and never carries.
    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        logic [6:0] r;
        if (up) r = (v >= hi) ? lo : v + 7'd1;
        else    r = (v <= lo) ? hi : v - 7'd1;
        return r;
    endfunction

    always_comb begin
        sec_n   = sec_q;
        min_n   = min_q;
        hour_n  = hour_q;
        day_n   = day_q;
        month_n = month_q;
        year_n  = year_q;
        presc_n = presc_q;
        tick_n  = 1'b0;
        cur_dim = days_in_month(month_q, year_q);
        new_dim = cur_dim;
        if (bus.edit_en) begin
            presc_n = '0;
            if (bus.inc_pulse ^ bus.dec_pulse) begin
                case (bus.edit_field)
                    FIELD_SEC:  sec_n  = 6'(wrap_step(7'(sec_q), 7'd0, 7'd59, bus.inc_pulse));
                    FIELD_MIN:  min_n  = 6'(wrap_step(7'(min_q), 7'd0, 7'd59, bus.inc_pulse));
                    FIELD_HOUR: hour_n = 5'(wrap_step(7'(hour_q), 7'd0, 7'd23, bus.inc_pulse));
                    FIELD_DAY:  day_n  = 5'(wrap_step(7'(day_q), 7'd1, 7'(cur_dim), bus.inc_pulse));
                    FIELD_MONTH: begin
                        month_n = 4'(wrap_step(7'(month_q), 7'd1, 7'd12, bus.inc_pulse));
                        new_dim = days_in_month(month_n, year_q);
                        if (day_q > new_dim) day_n = new_dim;
                    end
                    FIELD_YEAR: begin
                        year_n  = wrap_step(year_q, 7'd0, 7'd99, bus.inc_pulse);
                        new_dim = days_in_month(month_q, year_n);
                        if (day_q > new_dim) day_n = new_dim;
                    end
                    default: ;
                endcase
            end
        end else if (bus.run_en) begin
            if (presc_q == PRESC_LAST) begin
                presc_n = '0;
                tick_n  = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_n = '0;
                    if (min_q == 6'd59) begin
                        min_n = '0;
                        if (hour_q == 5'd23) begin
                            hour_n = '0;
                            if (day_q >= cur_dim) begin
                                day_n = 5'd1;
                                if (month_q == 4'd12) begin
                                    month_n = 4'd1;
                                    year_n  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                                end else begin
                                    month_n = month_q + 4'd1;
                                end
                            end else begin
                                day_n = day_q + 5'd1;
                            end
                        end else begin
                            hour_n = hour_q + 5'd1;
                        end
                    end else begin
                        min_n = min_q + 6'd1;
                    end
                end else begin
                    sec_n = sec_q + 6'd1;
                end
            end else begin
                presc_n = presc_q + PRESC_W'(1);
            end
        end
    end

    // The blink divider ignores run/edit so the edited field keeps flashing.
    always_comb begin
        blink_cnt_n = blink_cnt_q + BLINK_W'(1);
        blink_n     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_n = '0;
            blink_n     = ~blink_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= '0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            sec_q       <= sec_n;
            min_q       <= min_n;
            hour_q      <= hour_n;
            day_q       <= day_n;
            month_q     <= month_n;
            year_q      <= year_n;
            presc_q     <= presc_n;
            tick_q      <= tick_n;
            blink_cnt_q <= blink_cnt_n;
            blink_q     <= blink_n;
        end
    end

    always_comb begin
        if (hour_q == 5'd0)       hour12_c = 4'd12;
        else if (hour_q > 5'd12)  hour12_c = 4'(hour_q - 5'd12);
        else                      hour12_c = hour_q[3:0];
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.hour12   = hour12_c;
    assign bus.pm       = (hour_q >= 5'd12);
    assign bus.day      = day_q;
    assign bus.month    = month_q;
    assign bus.year     = year_q;
    assign bus.tick_1hz = tick_q;
    assign bus.blink    = blink_q;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Bench for rtc_calendar_core: directed calendar scenarios and random control traffic, compared
// against a model holding seconds-of-day plus a date advanced from a month-length table.
module tb_rtc_calendar_core;
    localparam int CLK_HZ     = 10;
    localparam int BLINK_HZ   = 1;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

    logic CLOCK_50 = 1'b0;
    logic reset;
    rtc_calendar_core_if bus();

    rtc_calendar_core #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    int m_sod, m_day, m_month, m_year, m_presc, m_cycles;
    bit m_tick;
    int month_len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int model_dim(int mo, int yr);
        if (mo == 2 && (yr % 4) == 0) return 29;
        return month_len[mo - 1];
    endfunction

    function automatic void model_second();
        m_sod = (m_sod + 1) % 86400;
        if (m_sod == 0) begin
            if (m_day == model_dim(m_month, m_year)) begin
                m_day = 1;
                if (m_month == 12) begin
                    m_month = 1;
                    m_year  = (m_year + 1) % 100;
                end else begin
                    m_month++;
                end
            end else begin
                m_day++;
            end
        end
    endfunction

    function automatic void model_edit(int field, int d);
        int s, mi, h, dim;
        s  = m_sod % 60;
        mi = (m_sod / 60) % 60;
        h  = m_sod / 3600;
        case (field)
            0: s  = (s + d + 60) % 60;
            1: mi = (mi + d + 60) % 60;
            2: h  = (h + d + 24) % 24;
            3: begin
                dim   = model_dim(m_month, m_year);
                m_day = (m_day - 1 + d + dim) % dim + 1;
            end
            4: m_month = (m_month - 1 + d + 12) % 12 + 1;
            5: m_year  = (m_year + d + 100) % 100;
            default: ;
        endcase
        m_sod = h * 3600 + mi * 60 + s;
        if (m_day > model_dim(m_month, m_year)) m_day = model_dim(m_month, m_year);
    endfunction

    function automatic void model_step();
        if (reset) begin
            m_sod = 0; m_day = 1; m_month = 1; m_year = 0;
            m_presc = 0; m_cycles = 0; m_tick = 0;
            return;
        end
        m_cycles++;
        m_tick = 0;
        if (bus.edit_en) begin
            m_presc = 0;
            if (bus.inc_pulse != bus.dec_pulse)
                model_edit(int'(bus.edit_field), bus.inc_pulse ? 1 : -1);
        end else if (bus.run_en) begin
            m_presc++;
            if (m_presc == CLK_HZ) begin
                m_presc = 0;
                m_tick  = 1;
                model_second();
            end
        end
    endfunction

    function automatic logic [39:0] exp_vec();
        int h;
        h = m_sod / 3600;
        return {6'(m_sod % 60), 6'((m_sod / 60) % 60), 5'(h), 4'(((h + 11) % 12) + 1), 1'(h >= 12),
                5'(m_day), 4'(m_month), 7'(m_year), m_tick, 1'((m_cycles / BLINK_HALF) % 2)};
    endfunction

    function automatic logic [39:0] act_vec();
        return {bus.sec, bus.min, bus.hour, bus.hour12, bus.pm, bus.day, bus.month, bus.year,
                bus.tick_1hz, bus.blink};
    endfunction

    task automatic step_clock();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run_en = 1'b0; bus.edit_en = 1'b0; bus.edit_field = 3'd0;
        bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0;
        step_clock();
        reset = 1'b0;
    endtask

    task automatic edit_step(input int field, input bit up);
        bus.edit_field = 3'(field);
        bus.inc_pulse  = up;
        bus.dec_pulse  = !up;
        step_clock();
        bus.inc_pulse  = 1'b0;
        bus.dec_pulse  = 1'b0;
    endtask

    // From a freshly reset 00:00:00, one decrement per time field lands on 23:59:59.
    task automatic set_end_of_day();
        edit_step(0, 1'b0);
        edit_step(1, 1'b0);
        edit_step(2, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.run_en = 1'b1; bus.edit_en = 1'b1; bus.edit_field = 3'd0;
        bus.inc_pulse = 1'b1; bus.dec_pulse = 1'b0;
        repeat (3) step_clock();
        checks++;
        if ({bus.sec, bus.min, bus.hour, bus.day, bus.month, bus.year, bus.tick_1hz, bus.blink}
            !== {6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 7'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h, expected 2000-01-01 00:00:00 vector %h",
                     act_vec(), exp_vec());
        end
        checks++;
        if ({bus.hour12, bus.pm} !== {4'd12, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_hour12: got %0d/%0d, expected 12/0", bus.hour12, bus.pm);
        end
        reset = 1'b0;
        bus.run_en = 1'b0; bus.edit_en = 1'b0; bus.inc_pulse = 1'b0;
    endtask

    task automatic test_tick_rollover();
        do_reset();
        bus.run_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step_clock();
            checks++;
            if (bus.tick_1hz !== (i == 10)) begin
                errors++;
                $display("[TB] FAIL first_tick: cycle %0d got tick %b, expected %b", i, bus.tick_1hz, i == 10);
            end
        end
        checks++;
        if (bus.sec !== 6'd1) begin
            errors++;
            $display("[TB] FAIL first_second: got sec %0d, expected 1", bus.sec);
        end
        for (int i = 0; i < 590; i++) begin
            step_clock();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL run_minute: cycle %0d got %h, expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if ({bus.min, bus.sec} !== {6'd1, 6'd0}) begin
            errors++;
            $display("[TB] FAIL minute_carry: got %0d:%0d, expected 1:0", bus.min, bus.sec);
        end
    endtask

    task automatic test_year_rollover();
        do_reset();
        bus.run_en  = 1'b1;
        bus.edit_en = 1'b1;
        set_end_of_day();
        edit_step(4, 1'b0);
        edit_step(3, 1'b0);
        checks++;
        if ({bus.day, bus.month, bus.hour, bus.min, bus.sec} !== {5'd31, 4'd12, 5'd23, 6'd59, 6'd59}) begin
            errors++;
            $display("[TB] FAIL nye_setup: got %h, expected %h", act_vec(), exp_vec());
        end
        bus.edit_en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step_clock();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL nye_run: cycle %0d got %h, expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if ({bus.tick_1hz, bus.year, bus.month, bus.day, bus.hour, bus.min, bus.sec}
            !== {1'b1, 7'd1, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL year_carry: got %h, expected 2001-01-01 00:00:00 with tick", act_vec());
        end
    endtask

    task automatic test_month_ends();
        int yinc[3] = '{0, 1, 0};
        int minc[3] = '{1, 1, 3};
        int ddec[3] = '{2, 1, 1};
        int emon[3] = '{2, 3, 5};
        int eday[3] = '{29, 1, 1};
        for (int s = 0; s < 3; s++) begin
            do_reset();
            bus.run_en  = 1'b1;
            bus.edit_en = 1'b1;
            repeat (yinc[s]) edit_step(5, 1'b1);
            repeat (minc[s]) edit_step(4, 1'b1);
            repeat (ddec[s]) edit_step(3, 1'b0);
            set_end_of_day();
            bus.edit_en = 1'b0;
            repeat (10) step_clock();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL month_end_vec: case %0d got %h, expected %h", s, act_vec(), exp_vec());
            end
            checks++;
            if ({bus.month, bus.day} !== {4'(emon[s]), 5'(eday[s])}) begin
                errors++;
                $display("[TB] FAIL month_end: case %0d got %0d/%0d, expected %0d/%0d",
                         s, bus.month, bus.day, emon[s], eday[s]);
            end
        end
    endtask

    task automatic test_day_clamp();
        do_reset();
        bus.edit_en = 1'b1;
        edit_step(3, 1'b0);
        checks++;
        if (bus.day !== 5'd31) begin
            errors++;
            $display("[TB] FAIL day_wrap_down: got %0d, expected 31", bus.day);
        end
        edit_step(4, 1'b1);
        checks++;
        if ({bus.month, bus.day} !== {4'd2, 5'd29}) begin
            errors++;
            $display("[TB] FAIL clamp_month: got %0d/%0d, expected 2/29", bus.month, bus.day);
        end
        edit_step(5, 1'b1);
        checks++;
        if ({bus.year, bus.day} !== {7'd1, 5'd28}) begin
            errors++;
            $display("[TB] FAIL clamp_year: got year %0d day %0d, expected 1/28", bus.year, bus.day);
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL clamp_vec: got %h, expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_edit_controls();
        do_reset();
        bus.run_en  = 1'b1;
        bus.edit_en = 1'b1;
        edit_step(0, 1'b0);
        checks++;
        if (bus.sec !== 6'd59) begin
            errors++;
            $display("[TB] FAIL sec_dec_wrap: got %0d, expected 59", bus.sec);
        end
        bus.edit_field = 3'd0; bus.inc_pulse = 1'b1; bus.dec_pulse = 1'b1;
        step_clock();
        bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0;
        checks++;
        if (bus.sec !== 6'd59) begin
            errors++;
            $display("[TB] FAIL inc_and_dec: got sec %0d, expected 59", bus.sec);
        end
        edit_step(6, 1'b1);
        checks++;
        if ({bus.sec, bus.min, bus.hour, bus.day, bus.month, bus.year}
            !== {6'd59, 6'd0, 5'd0, 5'd1, 4'd1, 7'd0}) begin
            errors++;
            $display("[TB] FAIL reserved_field: got %h, expected %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 30; i++) begin
            step_clock();
            checks++;
            if (bus.tick_1hz !== 1'b0 || act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL edit_freeze: cycle %0d got %h, expected %h", i, act_vec(), exp_vec());
            end
        end
        bus.edit_en = 1'b0;
        bus.run_en  = 1'b0;
        edit_step(0, 1'b1);
        checks++;
        if (bus.sec !== 6'd59) begin
            errors++;
            $display("[TB] FAIL pulse_outside_edit: got sec %0d, expected 59", bus.sec);
        end
        // 4 running + 25 stopped + 6 running cycles: the tick must land on the 6th.
        for (int i = 0; i < 35; i++) begin
            bus.run_en = (i < 4 || i >= 29);
            step_clock();
            checks++;
            if (bus.tick_1hz !== (i == 34) || act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL run_hold: cycle %0d got %h, expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if ({bus.min, bus.sec} !== {6'd1, 6'd0}) begin
            errors++;
            $display("[TB] FAIL run_hold_carry: got %0d:%0d, expected 1:0", bus.min, bus.sec);
        end
    endtask

    task automatic test_hour12_blink();
        bit prev;
        int last_tog;
        int ntog;
        do_reset();
        bus.edit_en = 1'b1;
        for (int h = 0; h < 24; h++) begin
            checks++;
            if ({bus.hour12, bus.pm} !== {4'(((h + 11) % 12) + 1), 1'(h >= 12)}) begin
                errors++;
                $display("[TB] FAIL hour12: hour %0d got %0d/%0d, expected %0d/%0d",
                         h, bus.hour12, bus.pm, ((h + 11) % 12) + 1, h >= 12);
            end
            edit_step(2, 1'b1);
        end
        prev = bus.blink;
        last_tog = -1;
        ntog = 0;
        for (int i = 1; i <= 20; i++) begin
            step_clock();
            if (bus.blink !== prev) begin
                ntog++;
                if (last_tog >= 0) begin
                    checks++;
                    if (i - last_tog !== BLINK_HALF) begin
                        errors++;
                        $display("[TB] FAIL blink_period: got %0d cycles, expected %0d", i - last_tog, BLINK_HALF);
                    end
                end
                last_tog = i;
                prev = bus.blink;
            end
        end
        checks++;
        if (ntog !== 4) begin
            errors++;
            $display("[TB] FAIL blink_toggles: got %0d toggles in 20 cycles, expected 4", ntog);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            bus.run_en     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) bus.edit_en = !bus.edit_en;
            bus.edit_field = 3'($urandom_range(0, 7));
            bus.inc_pulse  = ($urandom_range(0, 3) == 0);
            bus.dec_pulse  = ($urandom_range(0, 3) == 0);
            step_clock();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (shown < 10)
                    $display("[TB] FAIL random: cycle %0d got %h, expected %h", i, act_vec(), exp_vec());
                shown++;
            end
        end
        reset = 1'b0;
        bus.inc_pulse = 1'b0;
        bus.dec_pulse = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick_rollover();
        test_year_rollover();
        test_month_ends();
        test_day_clamp();
        test_edit_controls();
        test_hour12_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
